// File: rtl/codec_init_seq.sv
// Power-up register-write sequencer for the TLV320DAC3203 codec, feeding an I2C master byte by byte.
// Optional feature: define CODEC_INIT_READBACK_EN to read back and verify every written register.
module codec_init_seq #(
  parameter logic [6:0] DEV_ADDR      = 7'h18,
  parameter int         NUM_ENTRIES   = 8,
  parameter int         MS_CYCLES     = 12000,
  parameter int         STROBE_CYCLES = 4,
  parameter int         BUSY_TIMEOUT  = 4096
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       busy,
  input  logic [7:0] rdata,
  output logic [7:0] i2c_din,
  output logic       copy_enable,
  output logic       done,
  output logic       error,
  output logic [7:0] step
);

  typedef enum logic [3:0] {
    IDLE, LOAD, SETUP, STROBE_HI, STROBE_LO, WAIT_BUSY_HI, WAIT_BUSY_LO, DELAY, DONE
  } state_t;

  state_t      state_r, state_s;
  logic [31:0] cnt_r, cnt_s;
  logic [1:0]  byte_idx_r, byte_idx_s;
  logic [7:0]  din_r, din_s;
  logic        ce_r, ce_s;
  logic        done_r, done_s;
  logic        error_r, error_s;
  logic [7:0]  step_r, step_s;
  logic [15:0] entry_s;
  logic [7:0]  reg_s, val_s;
  logic        rd_s;
  logic [1:0]  last_s;

`ifdef CODEC_INIT_READBACK_EN
  logic        rd_r, cmp_r, rd_nxt_s, cmp_s;
  assign rd_s   = rd_r;
  assign last_s = rd_r ? 2'd1 : 2'd2;
`else
  logic        unused_rdata_s;
  assign unused_rdata_s = ^rdata;
  assign rd_s   = 1'b0;
  assign last_s = 2'd2;
`endif

  // {reg, val}; reg 8'hFF marks a delay of val milliseconds.
  function automatic logic [15:0] table_entry(input logic [7:0] idx);
    case (idx)
      8'd0:    return 16'h0000;
      8'd1:    return 16'h0101;
      8'd2:    return 16'hFF0A;
      8'd3:    return 16'h0403;
      8'd4:    return 16'h0591;
      8'd5:    return 16'h0B81;
      8'd6:    return 16'h0C82;
      8'd7:    return 16'h3FD6;
      default: return 16'hFF00;
    endcase
  endfunction

  function automatic logic [7:0] pick_byte(input logic [1:0] b, input logic rd,
                                           input logic [7:0] r, input logic [7:0] v);
    case (b)
      2'd0:    return {DEV_ADDR, rd};
      2'd1:    return r;
      default: return v;
    endcase
  endfunction

  assign entry_s = table_entry(step_r);
  assign reg_s   = entry_s[15:8];
  assign val_s   = entry_s[7:0];

  // Next-state and next-output logic for the sequencer.
  always_comb begin
    state_s    = state_r;
    cnt_s      = cnt_r;
    byte_idx_s = byte_idx_r;
    din_s      = din_r;
    ce_s       = ce_r;
    done_s     = done_r;
    error_s    = error_r;
    step_s     = step_r;
`ifdef CODEC_INIT_READBACK_EN
    rd_nxt_s   = rd_r;
    cmp_s      = cmp_r;
`endif
    case (state_r)
      IDLE, DONE: begin
        if (start) begin
          step_s  = 8'd0;
          error_s = 1'b0;
          done_s  = 1'b0;
          state_s = LOAD;
        end else begin
          state_s = state_r;
        end
      end
      LOAD: begin
        cnt_s = 32'd0;
        if (step_r == 8'(NUM_ENTRIES)) begin
          done_s  = 1'b1;
          state_s = DONE;
        end else if (reg_s == 8'hFF) begin
          // A zero-length delay costs only this LOAD cycle.
          if (val_s == 8'd0) begin
            step_s = step_r + 8'd1;
          end else begin
            cnt_s   = 32'(val_s) * 32'(MS_CYCLES) - 32'd1;
            state_s = DELAY;
          end
        end else begin
          byte_idx_s = 2'd0;
          din_s      = pick_byte(2'd0, 1'b0, reg_s, val_s);
`ifdef CODEC_INIT_READBACK_EN
          rd_nxt_s   = 1'b0;
`endif
          state_s    = SETUP;
        end
      end
      SETUP: begin
        if (cnt_r == 32'd1) begin
          cnt_s   = 32'd0;
          ce_s    = 1'b1;
          state_s = STROBE_HI;
        end else begin
          cnt_s = cnt_r + 32'd1;
        end
      end
      STROBE_HI: begin
        if (cnt_r == 32'(STROBE_CYCLES - 1)) begin
          cnt_s   = 32'd0;
          ce_s    = 1'b0;
          state_s = STROBE_LO;
        end else begin
          cnt_s = cnt_r + 32'd1;
        end
      end
      STROBE_LO: begin
        if (cnt_r == 32'd1) begin
          cnt_s = 32'd0;
          if (byte_idx_r < last_s) begin
            byte_idx_s = byte_idx_r + 2'd1;
            din_s      = pick_byte(byte_idx_r + 2'd1, rd_s, reg_s, val_s);
            state_s    = SETUP;
          end else begin
            state_s = WAIT_BUSY_HI;
          end
        end else begin
          cnt_s = cnt_r + 32'd1;
        end
      end
      WAIT_BUSY_HI: begin
        if (busy) begin
          cnt_s   = 32'd0;
          state_s = WAIT_BUSY_LO;
        end else if (cnt_r == 32'(BUSY_TIMEOUT - 1)) begin
          cnt_s   = 32'd0;
          error_s = 1'b1;
          step_s  = step_r + 8'd1;
          state_s = LOAD;
        end else begin
          cnt_s = cnt_r + 32'd1;
        end
      end
      WAIT_BUSY_LO: begin
`ifdef CODEC_INIT_READBACK_EN
        // The read result is compared the cycle after busy drops.
        if (cmp_r) begin
          cmp_s   = 1'b0;
          error_s = error_r | (rdata != val_s);
          step_s  = step_r + 8'd1;
          state_s = LOAD;
        end else if (!busy) begin
          if (rd_r) begin
            cmp_s = 1'b1;
          end else begin
            rd_nxt_s   = 1'b1;
            byte_idx_s = 2'd0;
            din_s      = pick_byte(2'd0, 1'b1, reg_s, val_s);
            cnt_s      = 32'd0;
            state_s    = SETUP;
          end
        end else begin
          cmp_s = 1'b0;
        end
`else
        if (!busy) begin
          step_s  = step_r + 8'd1;
          state_s = LOAD;
        end else begin
          state_s = WAIT_BUSY_LO;
        end
`endif
      end
      DELAY: begin
        if (cnt_r == 32'd0) begin
          step_s  = step_r + 8'd1;
          state_s = LOAD;
        end else begin
          cnt_s = cnt_r - 32'd1;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= IDLE;
      cnt_r      <= 32'd0;
      byte_idx_r <= 2'd0;
      din_r      <= 8'h00;
      ce_r       <= 1'b0;
      done_r     <= 1'b0;
      error_r    <= 1'b0;
      step_r     <= 8'd0;
`ifdef CODEC_INIT_READBACK_EN
      rd_r       <= 1'b0;
      cmp_r      <= 1'b0;
`endif
    end else begin
      state_r    <= state_s;
      cnt_r      <= cnt_s;
      byte_idx_r <= byte_idx_s;
      din_r      <= din_s;
      ce_r       <= ce_s;
      done_r     <= done_s;
      error_r    <= error_s;
      step_r     <= step_s;
`ifdef CODEC_INIT_READBACK_EN
      rd_r       <= rd_nxt_s;
      cmp_r      <= cmp_s;
`endif
    end
  end

  assign i2c_din     = din_r;
  assign copy_enable = ce_r;
  assign done        = done_r;
  assign error       = error_r;
  assign step        = step_r;

endmodule

// File: tb/tb_codec_init_seq.sv
// Directed self-checking bench for codec_init_seq with a simple I2C-master busy/rdata model.
module tb_codec_init_seq;
  localparam int MS_CYC  = 100;
  localparam int TIMEOUT = 64;
`ifdef CODEC_INIT_READBACK_EN
  localparam int EXP_BYTES = 35;
`else
  localparam int EXP_BYTES = 21;
`endif

  logic       clk = 1'b0;
  logic       reset, start, busy, copy_enable, done, error;
  logic [7:0] rdata, i2c_din, step;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  bit   busy_mode;
  logic [7:0] byte_q[$];
  int   rise_cyc[$];
  int   fall_cyc[$];

  typedef struct {
    int         idx;
    logic [7:0] exp_byte;
  } byte_vec_t;
  byte_vec_t bvec[21];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  codec_init_seq #(
    .DEV_ADDR(7'h18), .NUM_ENTRIES(8), .MS_CYCLES(MS_CYC),
    .STROBE_CYCLES(4), .BUSY_TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .rdata(rdata),
    .i2c_din(i2c_din), .copy_enable(copy_enable), .done(done), .error(error), .step(step)
  );

  function automatic logic [7:0] codec_reg(input logic [7:0] r);
    case (r)
      8'h00:   return 8'h00;
      8'h01:   return 8'h01;
      8'h04:   return 8'h03;
      8'h05:   return 8'h90;
      8'h0B:   return 8'h81;
      8'h0C:   return 8'h82;
      8'h3F:   return 8'hD6;
      default: return 8'h00;
    endcase
  endfunction

  // Strobe capture plus busy model: busy rises 10 cycles after a transaction's last strobe, lasts 500.
  initial begin
    automatic bit prev_ce = 1'b0;
    automatic int cd = 0;
    automatic int hold = 0;
    busy  = 1'b0;
    rdata = 8'h00;
    forever begin
      @(negedge clk);
      if (reset) begin
        busy = 1'b0; cd = 0; hold = 0;
      end
      if (copy_enable && !prev_ce) begin
        rise_cyc.push_back(cyc);
        cd = 0;
      end
      if (!copy_enable && prev_ce) begin
        byte_q.push_back(i2c_din);
        fall_cyc.push_back(cyc);
        if (byte_q.size() >= 2 && byte_q[byte_q.size()-2] == 8'h31)
          rdata = codec_reg(i2c_din);
        if (busy_mode) cd = 10;
      end else if (cd > 0) begin
        cd--;
        if (cd == 0) begin busy = 1'b1; hold = 500; end
      end else if (hold > 0) begin
        hold--;
        if (hold == 0) busy = 1'b0;
      end
      prev_ce = copy_enable;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic clear_caps();
    byte_q.delete();
    rise_cyc.delete();
    fall_cyc.delete();
  endtask

  task automatic wait_done(input int limit);
    int n;
    n = 0;
    while (!done && n < limit) begin @(negedge clk); n++; end
    check("done_reached", {31'd0, done}, 32'd1);
  endtask

  initial begin
    int n, f, base;
    bvec = '{'{0,8'h30}, '{1,8'h00}, '{2,8'h00}, '{3,8'h30}, '{4,8'h01}, '{5,8'h01},
             '{6,8'h30}, '{7,8'h04}, '{8,8'h03}, '{9,8'h30}, '{10,8'h05}, '{11,8'h91},
             '{12,8'h30}, '{13,8'h0B}, '{14,8'h81}, '{15,8'h30}, '{16,8'h0C}, '{17,8'h82},
             '{18,8'h30}, '{19,8'h3F}, '{20,8'hD6}};
    reset = 1'b1; start = 1'b0; busy_mode = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_din",  {24'd0, i2c_din}, 32'h00);
    check("rst_ce",   {31'd0, copy_enable}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_err",  {31'd0, error}, 32'd0);
    check("rst_step", {24'd0, step}, 32'd0);
    reset = 1'b0;

    // Full sequence; a start during WAIT_BUSY_LO of entry 3 must be ignored.
    clear_caps();
    pulse_start();
    n = 0;
    while (!(busy && step == 8'd3) && n < 20000) begin @(negedge clk); n++; end
    pulse_start();
    repeat (3) @(negedge clk);
    check("start_ignored_step", {24'd0, step}, 32'd3);
    check("start_ignored_done", {31'd0, done}, 32'd0);
    wait_done(20000);
    check("byte_count", byte_q.size(), EXP_BYTES);
`ifdef CODEC_INIT_READBACK_EN
    check("rb_error", {31'd0, error}, 32'd1);
    check("rb_b15", {24'd0, byte_q[15]}, 32'h30);
    check("rb_b16", {24'd0, byte_q[16]}, 32'h05);
    check("rb_b17", {24'd0, byte_q[17]}, 32'h91);
    check("rb_b18", {24'd0, byte_q[18]}, 32'h31);
    check("rb_b19", {24'd0, byte_q[19]}, 32'h05);
`else
    check("run_error", {31'd0, error}, 32'd0);
    for (int i = 0; i < 21; i++)
      check($sformatf("byte%0d", bvec[i].idx), {24'd0, byte_q[bvec[i].idx]}, {24'd0, bvec[i].exp_byte});
    // hold 2 + busy wait 9 + busy 500 + LOAD 1 + setup 2; delay entry adds 1001 (LOAD to LOAD)
    check("strobe_width", rise_cyc.size() > 0 ? fall_cyc[0] - rise_cyc[0] : 0, 32'd4);
    check("byte_gap",     rise_cyc[1] - fall_cyc[0], 32'd4);
    check("write_gap",    rise_cyc[3] - fall_cyc[2], 32'd514);
    check("delay_gap",    rise_cyc[6] - fall_cyc[5], 32'd1515);
`endif

    // Reset during STROBE_HI of entry 4, then replay.
    pulse_start();
    n = 0;
    while (!(step == 8'd4 && copy_enable) && n < 20000) begin @(negedge clk); n++; end
    check("reached_entry4_strobe", {31'd0, copy_enable}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    check("abort_ce",   {31'd0, copy_enable}, 32'd0);
    check("abort_din",  {24'd0, i2c_din}, 32'h00);
    check("abort_step", {24'd0, step}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    reset = 1'b0;
    base = rise_cyc.size();
    repeat (50) @(negedge clk);
    check("idle_no_strobe", rise_cyc.size(), base);
    clear_caps();
    pulse_start();
    wait_done(20000);
    check("replay_count", byte_q.size(), EXP_BYTES);
    check("replay_b0", {24'd0, byte_q[0]}, 32'h30);
    check("replay_b1", {24'd0, byte_q[1]}, 32'h00);
    check("replay_b2", {24'd0, byte_q[2]}, 32'h00);

    // busy never rises: timeout sets error and the sequence still completes.
    busy_mode = 1'b0;
    clear_caps();
    pulse_start();
    n = 0;
    while (fall_cyc.size() < 3 && n < 2000) begin @(negedge clk); n++; end
    f = fall_cyc[2];
    check("to_err_before", {31'd0, error}, 32'd0);
    n = 0;
    while (!error && n < 2000) begin @(negedge clk); n++; end
    check("to_latency", cyc - f, TIMEOUT + 2);
    wait_done(20000);
    check("to_error_sticky", {31'd0, error}, 32'd1);
    check("to_count", byte_q.size(), 21);

    // start from DONE clears error and done.
    busy_mode = 1'b1;
    pulse_start();
    check("restart_err", {31'd0, error}, 32'd0);
    check("restart_done", {31'd0, done}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
